// File: rtl/latch_mem_pkg.sv
// Shared types and helpers for the latch-based memory controller.
// Word count, address width, FSM states and the word-line decode.
package latch_mem_pkg;

    localparam int unsigned NWORDS = 4;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_RSEL,
        S_RCAP
    } state_t;

    // Captured request; write data is held directly in the DIN flops.
    typedef struct packed {
        logic              id;
        logic [ADDR_W-1:0] addr;
    } req_t;

    function automatic logic [NWORDS-1:0] onehot_dec(input logic [ADDR_W-1:0] a);
        onehot_dec    = '0;
        onehot_dec[a] = 1'b1;
    endfunction

endpackage

// File: rtl/latch_mem_ctrl_arb.sv
// Two-input round-robin arbiter; bit 0 = port A, bit 1 = port B.
// The last-grant register resets to B so A wins the first contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_b;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req == 2'b11)
                gnt = last_b ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_b <= 1'b1;
        else if (|gnt)
            last_b <= gnt[1];
    end

endmodule

// File: rtl/latch_mem_ctrl.sv
// Arbitration and word-line sequencing for the 4-word latch array.
// Word lines and DIN come straight from flops so latch enables never glitch.
module latch_mem_ctrl
    import latch_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_A,
    input  logic              REQ_B,
    input  logic              WE_A,
    input  logic              WE_B,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [WIDTH-1:0]  WDATA_A,
    input  logic [WIDTH-1:0]  WDATA_B,
    output logic              GNT_A,
    output logic              GNT_B,
    output logic              RVALID_A,
    output logic              RVALID_B,
    output logic [WIDTH-1:0]  RDATA,
    output logic              BUSY,
    output logic [NWORDS-1:0] RWL,
    output logic [NWORDS-1:0] WWL,
    output logic [WIDTH-1:0]  DIN,
    input  logic [WIDTH-1:0]  DOUT
);

    state_t             state, state_nxt;
    req_t               cap;
    logic [1:0]         gnt;
    logic               win_b;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [WIDTH-1:0]   win_wdata;

    rr_arb2 u_arb (
        .clk (CLK),
        .rst (RST),
        .en  (state == S_IDLE),
        .req ({REQ_B, REQ_A}),
        .gnt (gnt)
    );

    assign GNT_A     = gnt[0];
    assign GNT_B     = gnt[1];
    assign BUSY      = (state != S_IDLE);
    assign win_b     = gnt[1];
    assign win_we    = win_b ? WE_B    : WE_A;
    assign win_addr  = win_b ? ADDR_B  : ADDR_A;
    assign win_wdata = win_b ? WDATA_B : WDATA_A;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (|gnt) state_nxt = win_we ? S_WSETUP : S_RSEL;
            S_WSETUP: state_nxt = S_WPULSE;
            S_WPULSE: state_nxt = S_WHOLD;
            S_WHOLD:  state_nxt = S_IDLE;
            S_RSEL:   state_nxt = S_RCAP;
            S_RCAP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            cap      <= '0;
            RWL      <= '0;
            WWL      <= '0;
            DIN      <= '0;
            RDATA    <= '0;
            RVALID_A <= 1'b0;
            RVALID_B <= 1'b0;
        end else begin
            state    <= state_nxt;
            RVALID_A <= 1'b0;
            RVALID_B <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|gnt) begin
                        cap.id   <= win_b;
                        cap.addr <= win_addr;
                        // RWL is loaded at grant so the read mux sees it in RSEL.
                        if (win_we)
                            DIN <= win_wdata;
                        else
                            RWL <= onehot_dec(win_addr);
                    end
                end
                S_WSETUP: WWL <= onehot_dec(cap.addr);
                S_WPULSE: WWL <= '0;
                S_RCAP: begin
                    RDATA    <= DOUT;
                    RWL      <= '0;
                    RVALID_A <= ~cap.id;
                    RVALID_B <= cap.id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_mem_ctrl.sv
// Self-checking bench for latch_mem_ctrl: latch-array model, cycle scoreboard,
// vector table, directed corner sequences and a long random run.
module tb_latch_mem_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_A = 1'b0, REQ_B = 1'b0, WE_A = 1'b0, WE_B = 1'b0;
    logic [1:0] ADDR_A = '0, ADDR_B = '0;
    logic [7:0] WDATA_A = '0, WDATA_B = '0;
    logic       GNT_A, GNT_B, RVALID_A, RVALID_B, BUSY;
    logic [7:0] RDATA, DIN, DOUT;
    logic [3:0] RWL, WWL;

    latch_mem_ctrl #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .WE_A(WE_A), .WE_B(WE_B),
        .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .RVALID_A(RVALID_A), .RVALID_B(RVALID_B),
        .RDATA(RDATA), .BUSY(BUSY), .RWL(RWL), .WWL(WWL), .DIN(DIN), .DOUT(DOUT)
    );

    always #5 CLK = ~CLK;

    // Latch array and read muxes
    logic [7:0] arr [4];
    always @(WWL or DIN) begin
        for (int i = 0; i < 4; i++)
            if (WWL[i] === 1'b1) arr[i] = DIN;
    end
    always_comb begin
        DOUT = '0;
        for (int i = 0; i < 4; i++)
            if (RWL[i] === 1'b1) DOUT = arr[i];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: spec-timing model of every access
    logic [7:0] golden [4];
    logic [7:0] rq [$];
    logic [3:0] wwl_slot [8];
    logic [3:0] rwl_slot [8];
    logic [1:0] rv_slot  [8];
    logic       din_v    [8];
    logic [7:0] din_slot [8];
    int         busy_left = 0;
    logic       last_b = 1'b1;
    logic [7:0] hold = '0;
    logic [7:0] prev_din = '0;
    int         cyc = 0;

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            wwl_slot[i] = '0; rwl_slot[i] = '0; rv_slot[i] = '0;
            din_v[i] = 1'b0; din_slot[i] = '0;
        end
        rq.delete();
        busy_left = 0;
        last_b    = 1'b1;
        hold      = '0;
        prev_din  = '0;
    endtask

    always @(negedge CLK) begin
        int s;
        logic [1:0] eg;
        logic       ebusy, we;
        logic [1:0] ad;
        logic [7:0] wd;
        s = cyc % 8;
        if (RST) begin
            clear_model();
        end else begin
            ebusy = (busy_left != 0);
            chk("busy", 32'(BUSY), 32'(ebusy));
            eg = 2'b00;
            if (!ebusy) begin
                if (REQ_A && REQ_B) eg = last_b ? 2'b01 : 2'b10;
                else                eg = {REQ_B, REQ_A};
            end
            chk("gnt", 32'({GNT_B, GNT_A}), 32'(eg));
            chk("wwl", 32'(WWL), 32'(wwl_slot[s]));
            chk("rwl", 32'(RWL), 32'(rwl_slot[s]));
            if (din_v[s]) chk("din", 32'(DIN), 32'(din_slot[s]));
            if (WWL != 0) chk("din_stable", 32'(DIN), 32'(prev_din));
            chk("wl_invariants", 32'({$onehot0(RWL), $onehot0(WWL), !(|RWL && |WWL)}), 32'h7);
            if (rv_slot[s] != 0) begin
                if (rq.size() == 0) chk("rq_underflow", 32'(rq.size()), 32'd1);
                else                hold = rq.pop_front();
            end
            chk("rvalid", 32'({RVALID_B, RVALID_A}), 32'(rv_slot[s]));
            chk("rdata", 32'(RDATA), 32'(hold));
            wwl_slot[s] = '0; rwl_slot[s] = '0; rv_slot[s] = '0; din_v[s] = 1'b0;
            if (busy_left != 0) busy_left--;
            if (eg != 0) begin
                we = eg[1] ? WE_B : WE_A;
                ad = eg[1] ? ADDR_B : ADDR_A;
                wd = eg[1] ? WDATA_B : WDATA_A;
                last_b = eg[1];
                if (we) begin
                    busy_left = 3;
                    for (int k = 1; k <= 3; k++) begin
                        din_v[(cyc + k) % 8]    = 1'b1;
                        din_slot[(cyc + k) % 8] = wd;
                    end
                    wwl_slot[(cyc + 2) % 8] = 4'b0001 << ad;
                    golden[ad] = wd;
                end else begin
                    busy_left = 2;
                    rwl_slot[(cyc + 1) % 8] = 4'b0001 << ad;
                    rwl_slot[(cyc + 2) % 8] = 4'b0001 << ad;
                    rv_slot[(cyc + 3) % 8]  = eg;
                    rq.push_back(golden[ad]);
                end
            end
            prev_din = DIN;
        end
        cyc++;
    end

    typedef struct {
        logic       port_b;
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge CLK); #1;
            n++;
        end while (BUSY && n < 12);
        chk({nm, "_idle_timeout"}, 32'(BUSY), 32'd0);
    endtask

    task automatic do_access(input vec_t v);
        int n;
        logic got;
        @(posedge CLK); #1;
        if (v.port_b) begin REQ_B = 1; WE_B = v.we; ADDR_B = v.addr; WDATA_B = v.wdata; end
        else          begin REQ_A = 1; WE_A = v.we; ADDR_A = v.addr; WDATA_A = v.wdata; end
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge CLK); #1;
            got = v.port_b ? GNT_B : GNT_A;
            n++;
        end
        chk("access_grant", 32'(got), 32'd1);
        @(posedge CLK); #1;
        REQ_A = 0; REQ_B = 0;
        wait_idle("access");
        if (!v.we) chk("table_rdata", 32'(RDATA), 32'(v.exp_rdata));
    endtask

    initial begin
        logic [1:0] seq [4];
        int n, k, gap, grants;
        logic ga, gb;

        for (int i = 0; i < 4; i++) begin arr[i] = '0; golden[i] = '0; end
        clear_model();

        vecs[0]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 2'd2, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 8'h3C, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 2'd3, 8'hC3, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h3C};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 8'h00, 8'hC3};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 8'hFF, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 8'h00, 8'hFF};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h00};

        repeat (3) @(posedge CLK);
        #2 RST = 0;
        @(negedge CLK); #1;
        chk("reset_outputs", 32'({GNT_A, GNT_B, RVALID_A, RVALID_B, BUSY}), 32'd0);
        chk("reset_wl", 32'({RWL, WWL}), 32'd0);
        chk("reset_din_rdata", 32'({DIN, RDATA}), 32'd0);

        // Contention: both held, grants must alternate starting with A
        @(posedge CLK); #1;
        REQ_A = 1; WE_A = 0; ADDR_A = 2'd0;
        REQ_B = 1; WE_B = 0; ADDR_B = 2'd1;
        k = 0; n = 0;
        while (k < 4 && n < 40) begin
            @(negedge CLK); #1;
            n++;
            if (GNT_A || GNT_B) begin seq[k] = {GNT_B, GNT_A}; k++; end
        end
        @(posedge CLK); #1;
        REQ_A = 0; REQ_B = 0;
        chk("contention_count", 32'(k), 32'd4);
        for (int i = 0; i < k; i++)
            chk("contention_order", 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        wait_idle("contention");

        for (int i = 0; i < 11; i++) do_access(vecs[i]);

        // Back-to-back reads on B: grants exactly 3 cycles apart
        @(posedge CLK); #1;
        REQ_B = 1; WE_B = 0; ADDR_B = 2'd0;
        n = 0; gb = 0;
        while (!gb && n < 20) begin @(negedge CLK); #1; gb = GNT_B; n++; end
        chk("b2b_first_grant", 32'(gb), 32'd1);
        @(posedge CLK); #1;
        ADDR_B = 2'd3;
        gap = 1; gb = 0;
        while (!gb && gap < 20) begin @(negedge CLK); #1; gb = GNT_B; if (!gb) gap++; end
        chk("b2b_grant_gap", 32'(gap), 32'd3);
        @(posedge CLK); #1;
        REQ_B = 0;
        wait_idle("b2b");
        chk("b2b_rdata", 32'(RDATA), 32'hC3);

        // Reset asserted mid-WPULSE
        @(posedge CLK); #1;
        REQ_A = 1; WE_A = 1; ADDR_A = 2'd1; WDATA_A = 8'h77;
        n = 0; ga = 0;
        while (!ga && n < 20) begin @(negedge CLK); #1; ga = GNT_A; n++; end
        chk("rst_test_grant", 32'(ga), 32'd1);
        @(posedge CLK); #1;
        REQ_A = 0;
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("rst_test_wpulse", 32'(WWL), 32'b0010);
        #1 RST = 1;
        #1;
        chk("rst_async_wl", 32'({RWL, WWL}), 32'd0);
        chk("rst_async_outputs", 32'({GNT_A, GNT_B, RVALID_A, RVALID_B, BUSY}), 32'd0);
        chk("rst_async_din_rdata", 32'({DIN, RDATA}), 32'd0);
        chk("rst_word_intact", 32'(arr[1] == 8'hFF || arr[1] == 8'h77), 32'd1);
        @(negedge CLK); #2;
        RST = 0;
        golden[1] = arr[1];

        // Random traffic; the scoreboard checks every cycle
        grants = 0; ga = 0; gb = 0;
        for (int cy = 0; cy < 60000 && grants < 10000; cy++) begin
            @(posedge CLK); #1;
            if (ga) REQ_A = 0;
            if (gb) REQ_B = 0;
            if (!REQ_A && $urandom_range(1, 0) == 1) begin
                REQ_A = 1; WE_A = 1'($urandom_range(1, 0));
                ADDR_A = 2'($urandom_range(3, 0)); WDATA_A = 8'($urandom_range(255, 0));
            end
            if (!REQ_B && $urandom_range(1, 0) == 1) begin
                REQ_B = 1; WE_B = 1'($urandom_range(1, 0));
                ADDR_B = 2'($urandom_range(3, 0)); WDATA_B = 8'($urandom_range(255, 0));
            end
            @(negedge CLK); #1;
            ga = GNT_A; gb = GNT_B;
            grants += int'(GNT_A) + int'(GNT_B);
        end
        @(posedge CLK); #1;
        REQ_A = 0; REQ_B = 0;
        wait_idle("random");
        repeat (2) @(negedge CLK);
        chk("random_grant_count", 32'(grants >= 10000), 32'd1);
        chk("scoreboard_drained", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
